// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;
  localparam logic [5:0] FUNC_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_BEQ  = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Datapath <-> controller bundle: instruction fields in, control lines out.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] func_code;
  logic       mem_ready;
  logic       pc_en;
  logic       RegWrite;
  logic       RegDist;
  logic       AluSrc;
  logic [3:0] alu_ctrl;
  logic [1:0] Branch;
  logic       MemRead;
  logic       MemWrite;
  logic       MemReg;
  logic       illegal;
  logic       mem_err;
  logic       busy;

  // Datapath side.
  modport master (
    output op, func_code, mem_ready,
    input  pc_en, RegWrite, RegDist, AluSrc, alu_ctrl, Branch, MemRead, MemWrite, MemReg,
    input  illegal, mem_err, busy
  );

  // Controller side.
  modport slave (
    input  op, func_code, mem_ready,
    output pc_en, RegWrite, RegDist, AluSrc, alu_ctrl, Branch, MemRead, MemWrite, MemReg,
    output illegal, mem_err, busy
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decode.sv
// R-type function field to ALU operation; valid_o low for unsupported functions.
module alu_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] func_i,
  output logic [3:0] alu_ctrl_o,
  output logic       valid_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    valid_o    = 1'b1;
    case (func_i)
      FUNC_ADD: alu_ctrl_o = ALU_ADD;
      FUNC_SUB: alu_ctrl_o = ALU_SUB;
      FUNC_AND: alu_ctrl_o = ALU_AND;
      FUNC_OR:  alu_ctrl_o = ALU_OR;
      FUNC_SLT: alu_ctrl_o = ALU_SLT;
      FUNC_NOR: alu_ctrl_o = ALU_NOR;
      default:  valid_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Optional performance counters enabled by defining CTRL_PERF_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clock,
  input  logic               reset,
  multicycle_ctrl_if.slave   bus
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);

  state_e     state_q, state_d;
  logic [5:0] ir_op_q, ir_func_q;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       mem_err_q, mem_err_d;

  logic       pc_en, reg_write, reg_dist, alu_src, mem_read, mem_write, mem_reg;
  logic [3:0] alu;
  logic [1:0] branch;
  logic [3:0] r_alu;
  logic       r_valid;

  alu_decode u_alu_decode (
    .func_i     (ir_func_q),
    .alu_ctrl_o (r_alu),
    .valid_o    (r_valid)
  );

  logic is_r, is_lw, is_sw, is_addi, is_beq, is_bne, timeout_hit;
  assign is_r        = (ir_op_q == OP_RTYPE);
  assign is_lw       = (ir_op_q == OP_LW);
  assign is_sw       = (ir_op_q == OP_SW);
  assign is_addi     = (ir_op_q == OP_ADDI);
  assign is_beq      = (ir_op_q == OP_BEQ);
  assign is_bne      = (ir_op_q == OP_BNE);
  assign timeout_hit = (wait_q == 8'(MEM_TIMEOUT));

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    pc_en     = 1'b0;
    reg_write = 1'b0;
    reg_dist  = 1'b0;
    alu_src   = 1'b0;
    alu       = ALU_ADD;
    branch    = BR_NONE;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_reg   = 1'b0;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        if (is_r || is_lw || is_sw || is_addi || is_beq || is_bne) begin
          state_d = EXEC;
        end else begin
          illegal_d = 1'b1;
          pc_en     = 1'b1;
          state_d   = FETCH;
        end
      end
      EXEC: begin
        if (is_r) begin
          reg_dist = 1'b1;
          alu      = r_alu;
          if (r_valid) begin
            state_d = WB;
          end else begin
            illegal_d = 1'b1;
            pc_en     = 1'b1;
            state_d   = FETCH;
          end
        end else if (is_beq || is_bne) begin
          alu     = ALU_SUB;
          branch  = is_beq ? BR_BEQ : BR_BNE;
          pc_en   = 1'b1;
          state_d = FETCH;
        end else begin
          alu_src = 1'b1;
          state_d = is_addi ? WB : MEM;
        end
      end
      MEM: begin
        alu_src = 1'b1;
        // Abort cycle drops the strobes and ignores a late mem_ready.
        if (timeout_hit) begin
          mem_err_d = 1'b1;
          pc_en     = 1'b1;
          state_d   = FETCH;
        end else begin
          mem_read  = is_lw;
          mem_write = is_sw;
          if (bus.mem_ready) begin
            pc_en   = is_sw;
            state_d = is_sw ? FETCH : WB;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      WB: begin
        reg_write = 1'b1;
        pc_en     = 1'b1;
        reg_dist  = is_r;
        alu_src   = !is_r;
        alu       = is_r ? r_alu : ALU_ADD;
        mem_reg   = is_lw;
        mem_read  = is_lw;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      ir_op_q   <= '0;
      ir_func_q <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
      if (state_q == FETCH) begin
        ir_op_q   <= bus.op;
        ir_func_q <= bus.func_code;
      end
    end
  end

  // Reset gates every output so an in-flight strobe dies in the same cycle.
  assign bus.pc_en    = pc_en & ~reset;
  assign bus.RegWrite = reg_write & ~reset;
  assign bus.RegDist  = reg_dist & ~reset;
  assign bus.AluSrc   = alu_src & ~reset;
  assign bus.alu_ctrl = reset ? ALU_ADD : alu;
  assign bus.Branch   = reset ? BR_NONE : branch;
  assign bus.MemRead  = mem_read & ~reset;
  assign bus.MemWrite = mem_write & ~reset;
  assign bus.MemReg   = mem_reg & ~reset;
  assign bus.illegal  = illegal_q & ~reset;
  assign bus.mem_err  = mem_err_q & ~reset;
  assign bus.busy     = (state_q != FETCH) & ~reset;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, instr_q;
  logic             instr_inc;

  // Only completions of legal, non-aborted instructions are counted.
  assign instr_inc = pc_en & ((state_q == WB) ||
                              (state_q == MEM && !timeout_hit) ||
                              (state_q == EXEC && (is_beq || is_bne)));

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (instr_inc) begin
        instr_q <= instr_q + 1'b1;
      end
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 4).
module tb_multicycle_ctrl;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  multicycle_ctrl_if bus_if ();

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  multicycle_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
`ifdef CTRL_PERF_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {pc_en, RegWrite, RegDist, AluSrc, alu_ctrl, Branch, MemRead, MemWrite, MemReg,
  //  illegal, mem_err, busy}
  function automatic logic [15:0] o(input logic pc, input logic rw, input logic rd,
                                    input logic as, input logic [3:0] alu,
                                    input logic [1:0] br, input logic mr, input logic mw,
                                    input logic mreg, input logic ill, input logic merr,
                                    input logic bsy);
    return {pc, rw, rd, as, alu, br, mr, mw, mreg, ill, merr, bsy};
  endfunction

  function automatic logic [15:0] outs();
    return {bus_if.pc_en, bus_if.RegWrite, bus_if.RegDist, bus_if.AluSrc, bus_if.alu_ctrl,
            bus_if.Branch, bus_if.MemRead, bus_if.MemWrite, bus_if.MemReg, bus_if.illegal,
            bus_if.mem_err, bus_if.busy};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic rdy, input logic [15:0] e);
    @(negedge clock);
    reset            = rst;
    bus_if.mem_ready = rdy;
    #1;
    check_eq(tag, {16'h0, outs()}, {16'h0, e});
  endtask

  logic [5:0] r_func [6];
  logic [3:0] r_alu  [6];
  logic [15:0] rst_o;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus_if.op        = 6'b0;
    bus_if.func_code = 6'b0;
    bus_if.mem_ready = 1'b0;
    r_func = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    r_alu  = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
    rst_o  = o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 0);

    step("reset_0", 1, 0, rst_o);
    step("reset_1", 1, 0, rst_o);

    // R-type: 4 cycles, pc_en with RegWrite in WB
    for (int i = 0; i < 6; i++) begin
      bus_if.op        = 6'b000000;
      bus_if.func_code = r_func[i];
      step($sformatf("r%0d_fetch", i), 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 0));
      step($sformatf("r%0d_decode", i), 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 1));
      step($sformatf("r%0d_exec", i), 0, 0, o(0, 0, 1, 0, r_alu[i], 2'b00, 0, 0, 0, 0, 0, 1));
      step($sformatf("r%0d_wb", i), 0, 0, o(1, 1, 1, 0, r_alu[i], 2'b00, 0, 0, 0, 0, 0, 1));
    end

    // LW with two wait states: pc_en in cycle 7
    bus_if.op = 6'b100011;
    step("lw_fetch", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 0));
    step("lw_decode", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 1));
    step("lw_exec", 0, 0, o(0, 0, 0, 1, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 1));
    step("lw_mem1", 0, 0, o(0, 0, 0, 1, 4'b0010, 2'b00, 1, 0, 0, 0, 0, 1));
    step("lw_mem2", 0, 0, o(0, 0, 0, 1, 4'b0010, 2'b00, 1, 0, 0, 0, 0, 1));
    step("lw_mem3", 0, 1, o(0, 0, 0, 1, 4'b0010, 2'b00, 1, 0, 0, 0, 0, 1));
    step("lw_wb", 0, 0, o(1, 1, 0, 1, 4'b0010, 2'b00, 1, 0, 1, 0, 0, 1));

    // Branches: 3 cycles
    bus_if.op = 6'b000101;
    step("bne_fetch", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 0));
    step("bne_decode", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 1));
    step("bne_exec", 0, 0, o(1, 0, 0, 0, 4'b0110, 2'b10, 0, 0, 0, 0, 0, 1));
    bus_if.op = 6'b000100;
    step("beq_fetch", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 0));
    step("beq_decode", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 1));
    step("beq_exec", 0, 0, o(1, 0, 0, 0, 4'b0110, 2'b11, 0, 0, 0, 0, 0, 1));

    // SW zero wait: 4 cycles
    bus_if.op = 6'b101011;
    step("sw_fetch", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 0));
    step("sw_decode", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 1));
    step("sw_exec", 0, 0, o(0, 0, 0, 1, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 1));
    step("sw_mem", 0, 1, o(1, 0, 0, 1, 4'b0010, 2'b00, 0, 1, 0, 0, 0, 1));

    // Reset held 3 cycles in the middle of an SW MEM phase
    step("swr_fetch", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 0));
    step("swr_decode", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 1));
    step("swr_exec", 0, 0, o(0, 0, 0, 1, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 1));
    step("swr_mem1", 0, 0, o(0, 0, 0, 1, 4'b0010, 2'b00, 0, 1, 0, 0, 0, 1));
    step("swr_rst0", 1, 0, rst_o);
    step("swr_rst1", 1, 0, rst_o);
    step("swr_rst2", 1, 0, rst_o);

    // Illegal opcode skipped in DECODE, then ADDI completes with illegal sticky
    bus_if.op = 6'b111111;
    step("ill_fetch", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 0));
    step("ill_decode", 0, 0, o(1, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 1));
    bus_if.op = 6'b001000;
    step("addi_fetch", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 1, 0, 0));
    step("addi_decode", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 1, 0, 1));
    step("addi_exec", 0, 0, o(0, 0, 0, 1, 4'b0010, 2'b00, 0, 0, 0, 1, 0, 1));
    step("addi_wb", 0, 0, o(1, 1, 0, 1, 4'b0010, 2'b00, 0, 0, 0, 1, 0, 1));

    // SW timeout: MemWrite for 4 MEM cycles, then abort with pc_en
    bus_if.op = 6'b101011;
    step("swt_fetch", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 1, 0, 0));
    step("swt_decode", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 1, 0, 1));
    step("swt_exec", 0, 0, o(0, 0, 0, 1, 4'b0010, 2'b00, 0, 0, 0, 1, 0, 1));
    for (int i = 0; i < 4; i++) begin
      step($sformatf("swt_mem%0d", i), 0, 0, o(0, 0, 0, 1, 4'b0010, 2'b00, 0, 1, 0, 1, 0, 1));
    end
    step("swt_abort", 0, 0, o(1, 0, 0, 1, 4'b0010, 2'b00, 0, 0, 0, 1, 0, 1));
    step("swt_after", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 1, 1, 0));

    // Unsupported R function: flagged and skipped in EXEC
    step("badf_rst", 1, 0, rst_o);
    bus_if.op        = 6'b000000;
    bus_if.func_code = 6'b000000;
    step("badf_fetch", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 0));
    step("badf_decode", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 1));
    @(negedge clock);
    #1;
    check_eq("badf_exec_pc_en", {31'h0, bus_if.pc_en}, 32'd1);
    check_eq("badf_exec_regwrite", {31'h0, bus_if.RegWrite}, 32'd0);
    check_eq("badf_exec_busy", {31'h0, bus_if.busy}, 32'd1);
    step("badf_after", 0, 0, o(0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 1, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
